// File: rtl/space_pkg.sv
// Shared types and constants for the enemy formation block.
package space_pkg;

  // Formation life cycle: waiting for a wave, marching, or wave wiped out.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CLEARED = 2'd2
  } state_t;

  localparam int NUM_COLS_DEF = 10;
  localparam int NUM_ROWS_DEF = 6;

  // Geometry in pixels.
  localparam logic [9:0] COL_PITCH  = 10'd64;
  localparam logic [9:0] SPRITE_W   = 10'd32;
  localparam logic [9:0] ROW_TOP    = 10'd32;
  localparam logic [9:0] ROW_H      = 10'd32;
  localparam logic [9:0] OFFSET_MAX = 10'd32;
  localparam logic [9:0] STEP_PX    = 10'd4;

  // Sprite frame bases.
  localparam logic [7:0] FRAME_A = 8'd0;
  localparam logic [7:0] FRAME_B = 8'd8;

  // March period (frames per step) falls as the formation thins out.
  localparam logic [5:0] THR_0 = 6'd40;
  localparam logic [5:0] THR_1 = 6'd20;
  localparam logic [5:0] THR_2 = 6'd5;
  localparam logic [4:0] PER_0 = 5'd16;
  localparam logic [4:0] PER_1 = 5'd8;
  localparam logic [4:0] PER_2 = 5'd4;
  localparam logic [4:0] PER_3 = 5'd2;

  // Frames per step for a given alive count.
  function automatic logic [4:0] step_period(input logic [5:0] alive);
    if (alive >= THR_0)      return PER_0;
    else if (alive >= THR_1) return PER_1;
    else if (alive >= THR_2) return PER_2;
    else                     return PER_3;
  endfunction

endpackage

// File: rtl/enemy_hit_detect.sv
// Combinational missile-versus-formation hit test.
module enemy_hit_detect
  import space_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic                               i_exists,
  input  logic [9:0]                         i_x,
  input  logic [9:0]                         i_y,
  input  logic [9:0]                         i_offset,
  input  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  i_status,
  output logic                               o_hit_valid,
  output logic [3:0]                         o_hit_col,
  output logic [2:0]                         o_hit_row
);

  localparam logic [9:0] Y_END = 10'(32 + 32 * NUM_ROWS);

  logic [9:0] w_nx;
  logic       w_in_range;

  assign w_nx      = i_x - i_offset;
  assign o_hit_col = w_nx[9:6];
  assign o_hit_row = i_y[7:5] - 3'd1;

  // Missile is over a sprite cell (not a gap, not past the last column, inside the row band).
  assign w_in_range = i_exists && (i_x >= i_offset) && !w_nx[5] &&
                      ({1'b0, w_nx[9:6]} < 5'(NUM_COLS)) &&
                      (i_y >= ROW_TOP) && (i_y < Y_END);

  // Only an alive enemy under the missile counts as a hit.
  always_comb begin
    o_hit_valid = 1'b0;
    if (w_in_range) o_hit_valid = i_status[o_hit_col][o_hit_row];
  end

endmodule

// File: rtl/enemy_formation.sv
// Enemy formation: wave load, marching, missile hits and wave-cleared detection.
module enemy_formation
  import space_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int NUM_ROWS = NUM_ROWS_DEF
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_tick,
  input  logic                              start,
  input  logic                              pmissile_exists,
  input  logic [9:0]                        pMissileX,
  input  logic [9:0]                        pMissileY,
  output logic [9:0]                        enemy_offset,
  output logic [7:0]                        animation_offset,
  output logic [NUM_COLS-1:0][NUM_ROWS-1:0] enemy_status,
  output logic                              pmissile_hit,
  output logic                              all_dead,
  output logic [1:0]                        o_dbg_state,
  output logic [5:0]                        o_dbg_alive
);

  localparam logic [5:0] FULL_COUNT = 6'(NUM_COLS * NUM_ROWS);

  state_t                            r_state, w_state_n;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] r_status, w_status_n;
  logic [5:0]                        r_alive, w_alive_n;
  logic [9:0]                        r_offset, w_offset_n;
  logic                              r_dir, w_dir_n;   // 0 = right, 1 = left
  logic [7:0]                        r_anim, w_anim_n;
  logic [3:0]                        r_step, w_step_n;
  logic                              r_hit, w_hit_n;
  logic                              r_all_dead;

  logic       w_hit_valid;
  logic [3:0] w_hit_col;
  logic [2:0] w_hit_row;
  logic [4:0] w_last;

  // Hit test always uses the offset currently on the outputs (pre-step).
  enemy_hit_detect #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) u_hit (
    .i_exists    (pmissile_exists),
    .i_x         (pMissileX),
    .i_y         (pMissileY),
    .i_offset    (r_offset),
    .i_status    (r_status),
    .o_hit_valid (w_hit_valid),
    .o_hit_col   (w_hit_col),
    .o_hit_row   (w_hit_row)
  );

  assign w_last = step_period(r_alive) - 5'd1;

  // Next-state and datapath: reload beats everything, then hit and march combine.
  always_comb begin
    w_state_n  = r_state;
    w_status_n = r_status;
    w_alive_n  = r_alive;
    w_offset_n = r_offset;
    w_dir_n    = r_dir;
    w_anim_n   = r_anim;
    w_step_n   = r_step;
    w_hit_n    = 1'b0;
    if (start) begin
      w_state_n  = RUN;
      w_status_n = '1;
      w_alive_n  = FULL_COUNT;
      w_offset_n = '0;
      w_dir_n    = 1'b0;
      w_anim_n   = FRAME_A;
      w_step_n   = '0;
    end else if (r_state == RUN) begin
      if (w_hit_valid && (r_alive != 6'd0)) begin
        w_status_n[w_hit_col][w_hit_row] = 1'b0;
        w_alive_n = r_alive - 6'd1;
        w_hit_n   = 1'b1;
      end
      if (frame_tick) begin
        if ({1'b0, r_step} >= w_last) begin
          w_step_n = '0;
          w_anim_n = (r_anim == FRAME_A) ? FRAME_B : FRAME_A;
          if (!r_dir) begin
            if (r_offset + STEP_PX > OFFSET_MAX) w_dir_n = 1'b1;
            else                                 w_offset_n = r_offset + STEP_PX;
          end else begin
            if (r_offset < STEP_PX) w_dir_n = 1'b0;
            else                    w_offset_n = r_offset - STEP_PX;
          end
        end else begin
          w_step_n = r_step + 4'd1;
        end
      end
      // Last kill: freeze the formation where it stands.
      if (w_hit_n && (w_alive_n == 6'd0)) begin
        w_state_n  = CLEARED;
        w_offset_n = r_offset;
        w_anim_n   = r_anim;
        w_dir_n    = r_dir;
        w_step_n   = r_step;
      end
    end
  end

  // State and datapath registers; reset drops any pending update.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_status   <= '0;
      r_alive    <= '0;
      r_offset   <= '0;
      r_dir      <= 1'b0;
      r_anim     <= FRAME_A;
      r_step     <= '0;
      r_hit      <= 1'b0;
      r_all_dead <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_status   <= w_status_n;
      r_alive    <= w_alive_n;
      r_offset   <= w_offset_n;
      r_dir      <= w_dir_n;
      r_anim     <= w_anim_n;
      r_step     <= w_step_n;
      r_hit      <= w_hit_n;
      r_all_dead <= (w_state_n == CLEARED);
    end
  end

  assign enemy_offset     = r_offset;
  assign animation_offset = r_anim;
  assign enemy_status     = r_status;
  assign pmissile_hit     = r_hit;
  assign all_dead         = r_all_dead;
  assign o_dbg_state      = r_state;
  assign o_dbg_alive      = r_alive;

endmodule

// File: doc/enemy_formation.md
ENEMY_FORMATION -- requirements
Module: enemy_formation

Interface
REQ-001 Parameter NUM_COLS, default 10: enemy columns in the formation.
REQ-002 Parameter NUM_ROWS, default 6: enemy rows in the formation.
REQ-003 Clk  input  1: system clock; all state changes on its rising edge.
REQ-004 Reset  input  1: asynchronous, active-high reset.
REQ-005 frame_tick  input  1: one-Clk pulse per video frame.
REQ-006 start  input  1: one-Clk pulse that loads a fresh wave.
REQ-007 pmissile_exists  input  1: player missile in flight.
REQ-008 pMissileX, pMissileY  input  10 each: player missile pixel position.
REQ-009 enemy_offset  output  10: left X of column 0, feeds the colour mapper.
REQ-010 animation_offset  output  8: sprite frame base, either 0 or 8.
REQ-011 enemy_status  output  [9:0][5:0]: alive bit per [column][row].
REQ-012 pmissile_hit  output  1: one-Clk pulse when an alive enemy is destroyed.
REQ-013 all_dead  output  1: high while the formation is in state CLEARED.

Function
REQ-014 The block SHALL implement three states.
- IDLE: no movement, no hits.
- RUN: marching and hit detection active.
- CLEARED: all enemies dead, all_dead=1.
REQ-015 IDLE or CLEARED with start SHALL go to RUN next cycle, with:
- all 60 status bits set
- alive count = 60
- enemy_offset = 0, direction = right
- animation_offset = 0
- step counter = 0
REQ-016 start in RUN SHALL perform the same reload (restart mid-wave).
REQ-017 Geometry:
- column c occupies X [enemy_offset+64c, enemy_offset+64c+32)
- row r occupies Y [32+32r, 64+32r)
REQ-018 Hit condition, evaluated every Clk in RUN; nx = pMissileX - enemy_offset (10-bit):
- pmissile_exists=1
- pMissileX >= enemy_offset
- nx[5]=0
- nx[9:6] < NUM_COLS
- 32 <= pMissileY < 224
- enemy_status[nx[9:6]][pMissileY[7:5]-1] = 1
REQ-019 On a hit, the next edge SHALL clear that status bit, decrement the alive count, and assert pmissile_hit for exactly one cycle.
REQ-020 A hit on an already-dead enemy SHALL produce no pulse and no count change.
REQ-021 The step counter SHALL increment on each frame_tick in RUN.
REQ-022 When the step counter reaches period-1, it SHALL return to 0 and the formation SHALL step:
- enemy_offset moves 4 px in the current direction
- animation_offset toggles between 0 and 8
REQ-023 Period in frames, chosen from the alive count at the step decision:
- alive >= 40: 16
- alive >= 20: 8
- alive >= 5: 4
- otherwise: 2
REQ-024 Direction SHALL reverse when a step would leave the range 0 to 32 inclusive; that step leaves the offset unchanged and still toggles the animation.
REQ-025 Hit and step in the same cycle SHALL both take effect.
- Hit detection uses the pre-step enemy_offset.
REQ-026 The alive count going from 1 to 0 SHALL enter CLEARED on that edge.
- Offset and animation freeze.
REQ-027 start coinciding with a hit SHALL give the reload priority, and no pmissile_hit pulse is produced.
REQ-028 Widths and timing:
- alive count is 6 bits and never underflows.
- All outputs are registered.

Reset
REQ-029 Reset SHALL force the following, independent of Clk:
- state IDLE
- enemy_status all 0
- alive count 0
- enemy_offset 0, direction right
- animation_offset 0
- step counter 0
- pmissile_hit 0
- all_dead 0
REQ-030 Reset asserted mid-step or mid-hit SHALL discard that pending update.

Structure
REQ-031 Package space_pkg SHALL hold:
- the state enum (IDLE, RUN, CLEARED)
- NUM_COLS and NUM_ROWS defaults
- COL_PITCH=64, SPRITE_W=32, ROW_TOP=32, ROW_H=32
- OFFSET_MAX=32, STEP_PX=4
- FRAME_A=0, FRAME_B=8
- the four period thresholds and values
REQ-032 Hit geometry SHALL live in one combinational sub-module, enemy_hit_detect.
- Outputs: hit_valid, hit_col, hit_row.

Verification
REQ-033 Reset, then start -> next cycle:
- all status bits = 1
- offset = 0, animation = 0
- all_dead = 0
REQ-034 RUN with alive = 60, 16 frame_ticks -> offset 0 to 4, animation 0 to 8; 128 ticks from offset 0 -> offset reaches 32, then the next step reverses with offset held at 32.
REQ-035 Offset = 0, missile at (80,40) held 3 cycles -> single pmissile_hit pulse, enemy_status[1][0] = 0, alive count 59.
REQ-036 Missile at (100,40) with offset = 0 (gap, nx[5] = 1) -> no pulse, status unchanged.
REQ-037 Kill enemies until alive = 19 -> period becomes 4; kill the last enemy -> all_dead = 1 next cycle; start -> RUN with full status.
REQ-038 start and a valid hit on the same cycle -> full reload, no pulse; Reset asserted mid-RUN -> all outputs 0 immediately.
